tdm_demux_rx: RTL and testbench



---
 rtl/tdm_demux_rx.sv | 101 ++++++++++
 tb/tb_tdm_demux_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: two-channel 1-bit TDM receiver. Locks to a frame-sync marker,
// steers even slots to channel A and odd slots to channel B, and presents
// both assembled words with a one-cycle valid strobe.
module tdm_demux_rx #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din,
  input  logic         sync,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         valid,
  output logic         sync_err
);

  localparam int CW = $clog2(2 * W);
  localparam logic [CW-1:0] LAST = CW'(2 * W - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [W-1:0]   sh_a, sh_a_nxt;
  logic [W-1:0]   sh_b, sh_b_nxt;
  logic [W-1:0]   out_a_nxt, out_b_nxt;
  logic           valid_nxt, err_nxt;

  // State, slot counter, shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      cnt      <= '0;
      sh_a     <= '0;
      sh_b     <= '0;
      out_a    <= '0;
      out_b    <= '0;
      valid    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sh_a     <= sh_a_nxt;
      sh_b     <= sh_b_nxt;
      out_a    <= out_a_nxt;
      out_b    <= out_b_nxt;
      valid    <= valid_nxt;
      sync_err <= err_nxt;
    end
  end

  // Frame lock, slot steering and word completion
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_a_nxt  = sh_a;
    sh_b_nxt  = sh_b;
    out_a_nxt = out_a;
    out_b_nxt = out_b;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      HUNT: begin
        if (sync) begin
          sh_a_nxt  = {sh_a[W-2:0], din};
          cnt_nxt   = ONE;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (cnt == '0) begin
          if (sync) begin
            sh_a_nxt = {sh_a[W-2:0], din};
            cnt_nxt  = ONE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = HUNT;
          end
        end else if (sync) begin
          // Early sync: abandon the partial frame and restart at slot 0
          err_nxt  = 1'b1;
          sh_a_nxt = {{(W-1){1'b0}}, din};
          sh_b_nxt = '0;
          cnt_nxt  = ONE;
        end else if (cnt == LAST) begin
          // Last B bit goes straight to the output, bypassing sh_b
          out_a_nxt = sh_a;
          out_b_nxt = {sh_b[W-2:0], din};
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          if (cnt[0]) sh_b_nxt = {sh_b[W-2:0], din};
          else        sh_a_nxt = {sh_a[W-2:0], din};
          cnt_nxt = cnt + ONE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb_tdm_demux_rx: directed and randomized bench for tdm_demux_rx with a
// frame-level reference model built on a queue of received slot bits.
module tb_tdm_demux_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] out_a, out_b;
  logic         valid, sync_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit           q[$];
  bit           locked = 1'b0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic         m_v = 1'b0, m_e = 1'b0;

  tdm_demux_rx #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sync(sync),
    .out_a(out_a), .out_b(out_b), .valid(valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    locked = 1'b0;
    m_a = '0; m_b = '0; m_v = 1'b0; m_e = 1'b0;
  endtask

  // Frame rules: sync starts a frame; a locked receiver needs sync right
  // after each completed frame; 2W collected bits form one A/B word pair.
  task automatic model_step(input bit d, input bit s);
    m_v = 1'b0;
    m_e = 1'b0;
    if (s) begin
      if (locked && q.size() != 0) m_e = 1'b1;
      q.delete();
      q.push_back(d);
      locked = 1'b1;
    end else if (locked) begin
      if (q.size() == 0) begin
        m_e = 1'b1;
        locked = 1'b0;
      end else begin
        q.push_back(d);
        if (q.size() == 2 * W) begin
          for (int unsigned i = 0; i < W; i++) begin
            m_a[W-1-i] = q[2*i];
            m_b[W-1-i] = q[2*i+1];
          end
          m_v = 1'b1;
          q.delete();
        end
      end
    end
  endtask

  task automatic check_all();
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("valid", W'(valid), W'(m_v));
    chk("sync_err", W'(sync_err), W'(m_e));
  endtask

  // One serial cycle: drive at negedge, model after the edge, check #1 later
  task automatic step(input bit d, input bit s);
    din  = d;
    sync = s;
    @(posedge clk);
    if (rst_n) model_step(d, s);
    else model_reset();
    #1;
    check_all();
    @(negedge clk);
  endtask

  function automatic bit slot_bit(input logic [W-1:0] a, input logic [W-1:0] b, input int s);
    logic [W-1:0] wa, wb;
    wa = a;
    wb = b;
    return (s % 2 == 0) ? wa[W-1-s/2] : wb[W-1-(s-1)/2];
  endfunction

  task automatic send_slots(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    for (int s = 0; s < n; s++) step(slot_bit(a, b, s), s == 0);
  endtask

  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b);
    send_slots(a, b, 2 * W);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(bit'($urandom_range(0, 1)), 1'b0);
  endtask

  initial begin
    // Reset and idle with toggling data
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) step(bit'(i % 2), 1'b0);

    // Single frame, then hold
    send_frame(8'hA5, 8'h3C);
    chk("single_a", out_a, 8'hA5);
    chk("single_b", out_b, 8'h3C);
    idle(3);
    send_frame(8'hA5, 8'h3C);

    // Back-to-back frames
    send_frame(8'hFF, 8'h00);
    send_frame(8'h01, 8'h80);
    chk("b2b_a", out_a, 8'h01);
    chk("b2b_b", out_b, 8'h80);

    // Missing sync after a frame
    send_frame(8'h12, 8'h34);
    step(1'b0, 1'b0);
    idle(5);
    send_frame(8'h56, 8'h78);
    chk("miss_a", out_a, 8'h56);
    chk("miss_b", out_b, 8'h78);

    // Early sync at slot 7
    send_slots(8'hAA, 8'h55, 7);
    send_frame(8'hC3, 8'h3C);
    chk("early_a", out_a, 8'hC3);
    chk("early_b", out_b, 8'h3C);

    // Reset at slot 9 of the frame after (0x11, 0x22)
    send_frame(8'h11, 8'h22);
    send_slots(8'h77, 8'h33, 9);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    rst_n = 1'b1;
    send_frame(8'h99, 8'h66);
    chk("post_rst_a", out_a, 8'h99);
    chk("post_rst_b", out_b, 8'h66);

    // Randomized mix of frames, aborted frames and idle gaps
    for (int k = 0; k < 60; k++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 6)       send_frame(W'($urandom), W'($urandom));
      else if (r == 6) send_slots(W'($urandom), W'($urandom), int'($urandom_range(1, 2 * W - 1)));
      else             idle(int'($urandom_range(1, 4)));
    end
    send_frame(8'h5A, 8'hC6);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
